gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Global-history (gshare) conditional-branch direction predictor for the fetch stage. It works alongside the btb: the btb supplies the target, and this block supplies the taken/not-taken decision. Fetch combines both to form the next PC. The block trains on branch resolution from execute and restores its speculative history on a mispredict.

## Interface

Parameters:
- `PHT_ENTRIES`, default 256: pattern history table size. Must be a power of 2.
- `GHR_BITS`, default 8: global history length. Must equal log2(`PHT_ENTRIES`).

Ports:
- `clock`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `predict_valid`  in  1: fetch commits a prediction this cycle. Fetch drives it high when the btb hits on the fetch PC.
- `predict_pc`  in  `XLEN`: PC of the branch being predicted.
- `predict_taken`  out  1: predicted direction. Combinational.
- `predict_ghr`  out  `GHR_BITS`: GHR value used for this lookup. It travels with the branch down the pipeline.
- `resolve_valid`  in  1: a conditional branch resolved in execute this cycle.
- `resolve_pc`  in  `XLEN`: PC of the resolved branch.
- `resolve_ghr`  in  `GHR_BITS`: the `predict_ghr` snapshot that was carried with the resolved branch.
- `resolve_taken`  in  1: actual branch outcome.
- `resolve_mispredict`  in  1: the predicted direction was wrong. Only meaningful when `resolve_valid` is high.

## Operation

- State:
  - `ghr[GHR_BITS-1:0]`, the speculative global history.
  - `pht[PHT_ENTRIES]`, an array of 2-bit saturating counters: 0 = strong not-taken, 1 = weak not-taken, 2 = weak taken, 3 = strong taken.
- Lookup index: `pidx = predict_pc[GHR_BITS+1:2] ^ ghr`. Bits [1:0] are ignored because PCs are word-aligned.
- `predict_taken = pht[pidx][1]`.
- `predict_ghr = ghr`, including in cycles where `predict_valid` is low.
- Training index: `ridx = resolve_pc[GHR_BITS+1:2] ^ resolve_ghr`.
- On `resolve_valid`, `pht[ridx]` is updated at the clock edge:
  - Incremented if `resolve_taken` is high, saturating at 3.
  - Decremented otherwise, saturating at 0.
- GHR update priority, applied at the clock edge:
  1. If `resolve_valid && resolve_mispredict`: `ghr <= {resolve_ghr[GHR_BITS-2:0], resolve_taken}`. This is the recovery path, and any predict update in the same cycle is discarded.
  2. Else if `predict_valid`: `ghr <= {ghr[GHR_BITS-2:0], predict_taken}`. This is the speculative shift.
  3. Otherwise `ghr` holds its value.
- If `predict_valid` and `resolve_valid` hit the same `pht` entry in one cycle, the prediction reads the old counter value. There is no bypass.
- A correctly predicted resolve only trains the counter. It never touches `ghr`.
- Counter arithmetic is 2-bit. Saturation must be explicit and must not rely on wrap-around: 3 stays 3 on taken, 0 stays 0 on not-taken.

## Timing

- Reset, asynchronous:
  - Every `pht` entry goes to 1 (weak not-taken).
  - `ghr` goes to 0.
  - Outputs therefore read `predict_taken` = 0 and `predict_ghr` = 0 immediately, with no clock edge needed.
- Reset asserted mid-operation aborts all in-flight updates on that edge.
- Lookup latency is 0 cycles: `predict_taken` and `predict_ghr` are combinational from `predict_pc` and current state, the same as the btb lookup.
- Training latency is 1 cycle: a resolve at edge N is visible to lookups after edge N.
- Recovery latency is 1 cycle: a lookup in the cycle after the mispredict edge uses the repaired `ghr`.
- There is no handshake and no stall. The block accepts one predict and one resolve per cycle.

## Structure

- The following belong in `sys_defs.svh`:
  - Constants `BP_PHT_ENTRIES` and `BP_GHR_BITS`, used as the parameter defaults.
  - Typedef `BP_COUNTER`, an enum {`BP_STRONG_NT`, `BP_WEAK_NT`, `BP_WEAK_T`, `BP_STRONG_T`}.
  - A pure function `bp_counter_update(BP_COUNTER c, logic taken)` that performs the saturating increment/decrement.
- No sub-module is needed. The PHT is a flop array inside `gshare_predictor`. Expected size is about 150 lines of RTL.

## Test plan

- **Reset:** assert `reset`, then query `predict_pc` = 0x0 through 0x3FC in steps of 4 → `predict_taken` = 0 for all 256 entries and `predict_ghr` = 0.
- **Training and saturation:** from reset, apply 2 resolves with pc=0x40, ghr=0, taken=1 → lookup at pc=0x40 with ghr 0 predicts taken after the first resolve. Apply 3 more taken resolves, then 1 not-taken → still taken, because the counter saturated at 3 and dropped to 2. Apply 2 more not-taken → not-taken.
- **Speculative history:** from reset, hold `predict_valid` for 3 cycles while the PHT predicts taken at each index → `ghr` goes 0x01, 0x03, 0x07, and `predict_ghr` reflects each step on the following cycle.
- **Mispredict recovery:** from `ghr` = 0xA5, resolve with resolve_ghr=0x12, taken=1, mispredict=1, while `predict_valid` is also high → next `ghr` = 0x25, and the predict shift is discarded.
- **Same-entry collision:** in one cycle, predict and resolve (taken) on the same index whose counter is 1 → `predict_taken` = 0 that cycle, and 1 on the next lookup.
- **Async reset mid-run:** after random traffic, pulse `reset` between clock edges → outputs go to 0 before the next edge, and all counters read back 1.

Source files
------------

// File: rtl/gshare_predictor_pkg.sv
// Shared constants, counter encoding and counter update helper for the
// gshare direction predictor.
package gshare_predictor_pkg;

  localparam int XLEN           = 32;
  localparam int BP_PHT_ENTRIES = 256;
  localparam int BP_GHR_BITS    = 8;

  // 2-bit saturating direction counter; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    BP_STRONG_NT = 2'd0,
    BP_WEAK_NT   = 2'd1,
    BP_WEAK_T    = 2'd2,
    BP_STRONG_T  = 2'd3
  } BP_COUNTER;

  // Saturating step toward the observed outcome; the end states are held
  // explicitly so the counter can never wrap.
  function automatic BP_COUNTER bp_counter_update(BP_COUNTER c, logic taken);
    BP_COUNTER n;
    n = c;
    if (taken) begin
      case (c)
        BP_STRONG_NT: n = BP_WEAK_NT;
        BP_WEAK_NT:   n = BP_WEAK_T;
        BP_WEAK_T:    n = BP_STRONG_T;
        default:      n = BP_STRONG_T;
      endcase
    end else begin
      case (c)
        BP_STRONG_T:  n = BP_WEAK_T;
        BP_WEAK_T:    n = BP_WEAK_NT;
        BP_WEAK_NT:   n = BP_STRONG_NT;
        default:      n = BP_STRONG_NT;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch direction predictor. Lookup is combinational
// from the fetch PC xor the speculative global history; training and
// history recovery come from execute and take effect at the next edge.
// No handshake: one predict and one resolve may arrive every cycle.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int PHT_ENTRIES = BP_PHT_ENTRIES,
  parameter int GHR_BITS    = BP_GHR_BITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                predict_valid,
  input  logic [XLEN-1:0]     predict_pc,
  output logic                predict_taken,
  output logic [GHR_BITS-1:0] predict_ghr,
  input  logic                resolve_valid,
  input  logic [XLEN-1:0]     resolve_pc,
  input  logic [GHR_BITS-1:0] resolve_ghr,
  input  logic                resolve_taken,
  input  logic                resolve_mispredict
);

  BP_COUNTER           pht_q [PHT_ENTRIES];
  BP_COUNTER           pht_d [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;

  logic [GHR_BITS-1:0] pidx;
  logic [GHR_BITS-1:0] ridx;
  logic [1:0]          pred_cnt;

  // PC bits outside the index field carry no information for this table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{predict_pc[XLEN-1:GHR_BITS+2], predict_pc[1:0],
                            resolve_pc[XLEN-1:GHR_BITS+2], resolve_pc[1:0]};

  assign pidx = predict_pc[GHR_BITS+1:2] ^ ghr_q;
  assign ridx = resolve_pc[GHR_BITS+1:2] ^ resolve_ghr;

  // Combinational lookup; reads the stored counter, never the one being trained.
  always_comb begin
    pred_cnt      = pht_q[pidx];
    predict_taken = pred_cnt[1];
    predict_ghr   = ghr_q;
  end

  // Counter training: only the resolved entry moves.
  always_comb begin
    pht_d = pht_q;
    if (resolve_valid) begin
      pht_d[ridx] = bp_counter_update(pht_q[ridx], resolve_taken);
    end
  end

  // History update: mispredict recovery beats the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (resolve_valid && resolve_mispredict) begin
      ghr_d = {resolve_ghr[GHR_BITS-2:0], resolve_taken};
    end else if (predict_valid) begin
      ghr_d = {ghr_q[GHR_BITS-2:0], predict_taken};
    end
  end

  // State registers; reset puts every counter at weak not-taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= BP_WEAK_NT;
      end
    end else begin
      ghr_q <= ghr_d;
      pht_q <= pht_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a table model.
module tb_gshare_predictor;
  import gshare_predictor_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        predict_valid;
  logic [31:0] predict_pc;
  logic        predict_taken;
  logic [7:0]  predict_ghr;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [7:0]  resolve_ghr;
  logic        resolve_taken;
  logic        resolve_mispredict;

  gshare_predictor dut (
    .clock              (clock),
    .reset              (reset),
    .predict_valid      (predict_valid),
    .predict_pc         (predict_pc),
    .predict_taken      (predict_taken),
    .predict_ghr        (predict_ghr),
    .resolve_valid      (resolve_valid),
    .resolve_pc         (resolve_pc),
    .resolve_ghr        (resolve_ghr),
    .resolve_taken      (resolve_taken),
    .resolve_mispredict (resolve_mispredict)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Counters held as plain integers 0..3, history as an integer 0..255.
  int pht_m [256];
  int ghr_m;

  function automatic int m_idx(input logic [31:0] pc, input int g);
    return ((pc >> 2) % 256) ^ g;
  endfunction

  function automatic int m_taken(input logic [31:0] pc);
    return (pht_m[m_idx(pc, ghr_m)] >= 2) ? 1 : 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) pht_m[i] = 1;
      ghr_m = 0;
    end else begin
      int pt;
      int r;
      pt = m_taken(predict_pc);
      if (resolve_valid) begin
        r = m_idx(resolve_pc, resolve_ghr);
        if (resolve_taken) pht_m[r] = (pht_m[r] == 3) ? 3 : pht_m[r] + 1;
        else               pht_m[r] = (pht_m[r] == 0) ? 0 : pht_m[r] - 1;
      end
      if (resolve_valid && resolve_mispredict)
        ghr_m = ((resolve_ghr * 2) % 256) + (resolve_taken ? 1 : 0);
      else if (predict_valid)
        ghr_m = ((ghr_m * 2) % 256) + pt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    chk("cyc_taken", {31'd0, predict_taken}, m_taken(predict_pc));
    chk("cyc_ghr", {24'd0, predict_ghr}, ghr_m);
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    predict_valid      = 1'b0;
    predict_pc         = '0;
    resolve_valid      = 1'b0;
    resolve_pc         = '0;
    resolve_ghr        = '0;
    resolve_taken      = 1'b0;
    resolve_mispredict = 1'b0;
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic rv,
                       input logic [31:0] rpc, input logic [7:0] rg,
                       input logic rt, input logic rm);
    @(posedge clock);
    #1;
    predict_valid      = pv;
    predict_pc         = ppc;
    resolve_valid      = rv;
    resolve_pc         = rpc;
    resolve_ghr        = rg;
    resolve_taken      = rt;
    resolve_mispredict = rm;
  endtask

  task automatic peek(input string name, input logic exp_t, input logic [7:0] exp_g);
    #1;
    chk({name, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
    chk({name, "_ghr"}, {24'd0, predict_ghr}, {24'd0, exp_g});
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic reset_pulse();
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk("async_rst_taken", {31'd0, predict_taken}, 32'd0);
       chk("async_rst_ghr", {24'd0, predict_ghr}, 32'd0);
    #1 reset = 1'b0;
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();

    // Reset: every entry reads weak not-taken, history zero.
    #1;
    for (int i = 0; i < 256; i++) begin
      predict_pc = 32'(i * 4);
      peek("rst_sweep", 1'b0, 8'h00);
    end
    predict_pc = '0;
    @(posedge clock);
    #1 reset = 1'b0;

    // Training and saturation at pc 0x40, ghr 0 (entry 0x10).
    drive(1'b0, 32'h0, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("train_1", 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("sat_drop", 1'b1, 8'h00);
    drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 32'h40, 1'b1, 32'h40, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("train_nt", 1'b0, 8'h00);

    // Speculative history: make entries 0x10, 0x11, 0x13 taken, then predict.
    reset_pulse();
    drive(1'b0, 32'h0, 1'b1, 32'h40, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h40, 8'h01, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 32'h40, 8'h03, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("spec_0", 1'b1, 8'h00);
    drive(1'b1, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("spec_1", 1'b1, 8'h01);
    drive(1'b1, 32'h40, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("spec_3", 1'b1, 8'h03);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("spec_7", 1'b0, 8'h07);

    // Mispredict recovery: reach 0xA5, then repair to 0x25 over a predict.
    drive(1'b0, 32'h0, 1'b1, 32'h0, 8'h52, 1'b1, 1'b1);
    drive(1'b1, 32'h40, 1'b1, 32'h0, 8'h12, 1'b1, 1'b1);
    #1 chk("recov_pre_ghr", {24'd0, predict_ghr}, 32'h0000_00A5);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    #1 chk("recov_ghr", {24'd0, predict_ghr}, 32'h0000_0025);

    // Same-entry collision: prediction sees the old counter.
    reset_pulse();
    drive(1'b1, 32'h80, 1'b1, 32'h80, 8'h00, 1'b1, 1'b0);
    peek("coll_same", 1'b0, 8'h00);
    drive(1'b0, 32'h80, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    peek("coll_next", 1'b1, 8'h00);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(0, 1)),
            {$urandom_range(0, 15), 28'd0} | 32'($urandom_range(0, 1023)),
            1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255) * 4),
            8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
    end

    // Async reset mid-run, then every counter must read weak not-taken.
    reset_pulse();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 32'(i * 4), 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
      peek("post_rst", 1'b0, 8'h00);
    end

    @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
